subbytes_shiftrows: RTL and testbench
=====================================

Name: subbytes_shiftrows

Overview:
- Encryption round stage directly upstream of the MixColumns stage.
- Takes one 128-bit AES state, applies SubBytes to every byte, then ShiftRows.
- Presents the result with a single-cycle valid pulse, in the same byte ordering and tvalid/valid style the MixColumns stage consumes.
- SubBytes is iterative: SBOX_LANES S-box instances are time-shared, so area is traded for latency.

Parameters:
- SBOX_LANES, 4, number of parallel S-box instances. Legal values: 1, 2, 4, 8, 16. Elaboration error otherwise.
- NPASS, 16/SBOX_LANES (derived localparam, not overridable), number of substitution cycles per block.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- tvalid  in  1  input state valid; sampled only when ready=1.
- last_in  in  1  sideband flag: final AES round (MixColumns is bypassed downstream); captured with the state.
- state_in  in  128  input state. Byte i = state_in[8*(15-i) +: 8]. Column-major: byte 4c+r = row r, column c.
- ready  out  1  high in IDLE only; combinational from the FSM state.
- valid  out  1  one-cycle pulse: state_out and last_out are new.
- last_out  out  1  last_in of the block being presented.
- state_out  out  128  ShiftRows(SubBytes(state_in)), same byte ordering as state_in.

Behaviour:
- Reset (reset=1 at a rising edge):
  - FSM to IDLE, counter to 0, internal buffers to 0.
  - valid=0, last_out=0, state_out=128'h0.
  - Overrides everything, including a block in progress; that block is discarded with no valid pulse.
- FSM states:
  - IDLE (ready=1): an edge with tvalid=1 captures state_in into in_buf and last_in into last_buf, sets cnt=0, and moves to BUSY. tvalid=0 stays in IDLE.
  - BUSY (ready=0): each edge substitutes bytes cnt*SBOX_LANES .. cnt*SBOX_LANES+SBOX_LANES-1 of in_buf into sub_buf, then cnt++.
  - On the edge where cnt==NPASS-1:
    - state_out <= ShiftRows of the completed sub_buf, including the group written on this edge (bypass the final group, do not wait a cycle).
    - last_out <= last_buf; valid <= 1; FSM to IDLE.
- ShiftRows: out byte 4c+r = sub byte 4*((c+r) mod 4)+r. Row 0 unrotated; rows 1/2/3 rotate left by 1/2/3 columns.
- valid is 0 on every edge except the completion edge; it never stays high for two consecutive cycles.
- state_out and last_out hold their value until the next completion or reset.
- Latency:
  - Accept edge k gives valid=1 in the cycle after edge k+NPASS.
  - With the default SBOX_LANES=4: accept at edge 0, valid visible after edge 4.
- Throughput:
  - In the cycle where valid=1, ready is also 1, so a new block can be accepted at the next edge.
  - One block per NPASS+1 cycles.
- tvalid=1 while ready=0 is ignored: no capture and no effect on the block in flight. Upstream must hold until ready.
- No backpressure on the output side; the downstream stage always accepts.
- SBOX_LANES=16 gives NPASS=1: every block completes on the edge after acceptance.
- S-box: the FIPS-197 forward table. Each instance is purely combinational, 8-bit in and 8-bit out.

Decomposition:
- Shared package aes_pkg:
  - AES_STATE_W=128, AES_NBYTES=16.
  - Byte-index helper byte_idx(col,row)=4*col+row.
  - The 256-entry forward S-box constant array. The key expansion and other stages reuse it.
- Sub-module aes_sbox: one combinational byte lookup indexing the aes_pkg table. Instantiate SBOX_LANES copies in a generate loop.
- ShiftRows is fixed wiring inside this block; no separate module.

Test Plan:
- FIPS-197 App. B round 1:
  - Stimulus: state_in=193de3bea0f4e22b9ac68d2ae9f84808, last_in=0.
  - Response: state_out=d4bf5d30e0b452aeb84111f11e2798e5, valid pulse exactly 4 cycles after accept, last_out=0.
- All-zero input with last_in=1 -> state_out=6363…63 (16 bytes of 63), last_out=1. Repeat with all-ff -> 1616…16.
- Back-to-back:
  - Stimulus: hold tvalid=1 with two different states.
  - Response: second accepted on the edge after the first valid; valids 5 cycles apart; tvalid during BUSY ignored.
- Reset mid-operation:
  - Stimulus: accept a block, assert reset 2 cycles later for 1 cycle.
  - Response: no valid pulse, state_out=0, ready=1 the cycle after reset.
- Parameter sweep SBOX_LANES=1/2/8/16:
  - Stimulus: the App. B vector.
  - Response: identical state_out, with latency 16/8/2/1 cycles respectively.
- Scoreboard: 1000 random states against a software SubBytes+ShiftRows model. Check that valid is never high on two consecutive cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, byte indexing, forward S-box table
// and the ShiftRows permutation used by the encryption round stages.
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_NBYTES  = 16;

    typedef enum logic {
        SBSR_IDLE,
        SBSR_BUSY
    } sbsr_state_e;

    function automatic int unsigned byte_idx(input int unsigned col, input int unsigned row);
        return 4 * col + row;
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Row r of the state rotates left by r columns; byte i lives at bits [8*(15-i) +: 8].
    function automatic logic [AES_STATE_W-1:0] shift_rows(input logic [AES_STATE_W-1:0] s);
        logic [AES_STATE_W-1:0] res;
        res = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                res[8*(15-byte_idx(c, r)) +: 8] = s[8*(15-byte_idx((c + r) % 4, r)) +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single forward AES S-box lookup; purely combinational.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    always_comb begin
        out_byte = SBOX[in_byte];
    end

endmodule

// File: rtl/subbytes_shiftrows.sv
// Iterative SubBytes followed by ShiftRows; SBOX_LANES S-boxes are reused over
// NPASS cycles per block, result presented with a one-cycle valid pulse.
module subbytes_shiftrows
    import aes_pkg::*;
#(
    parameter int unsigned SBOX_LANES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tvalid,
    input  logic                   last_in,
    input  logic [AES_STATE_W-1:0] state_in,
    output logic                   ready,
    output logic                   valid,
    output logic                   last_out,
    output logic [AES_STATE_W-1:0] state_out
);

    localparam int unsigned NPASS = AES_NBYTES / SBOX_LANES;
    localparam int unsigned CNT_W = (NPASS > 1) ? $clog2(NPASS) : 1;

    if (!(SBOX_LANES inside {1, 2, 4, 8, 16})) begin : g_bad_lanes
        $error("subbytes_shiftrows: SBOX_LANES must be 1, 2, 4, 8 or 16");
    end

    sbsr_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AES_STATE_W-1:0] in_buf_q, in_buf_d;
    logic [AES_STATE_W-1:0] sub_buf_q, sub_buf_d;
    logic                   last_buf_q, last_buf_d;
    logic                   valid_q, valid_d;
    logic                   last_out_q, last_out_d;
    logic [AES_STATE_W-1:0] state_out_q, state_out_d;

    logic [7:0]             lane_in  [SBOX_LANES];
    logic [7:0]             lane_out [SBOX_LANES];
    logic [AES_STATE_W-1:0] sub_full;
    int unsigned            grp_base;

    for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
        aes_sbox u_sbox (
            .in_byte  (lane_in[l]),
            .out_byte (lane_out[l])
        );
    end

    // sub_full merges this cycle's group so the completion edge needs no extra cycle.
    always_comb begin
        grp_base = 32'(cnt_q) * SBOX_LANES;
        sub_full = sub_buf_q;
        for (int unsigned l = 0; l < SBOX_LANES; l++) begin
            lane_in[l] = in_buf_q[8*(15-(grp_base+l)) +: 8];
            sub_full[8*(15-(grp_base+l)) +: 8] = lane_out[l];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_buf_d    = in_buf_q;
        sub_buf_d   = sub_buf_q;
        last_buf_d  = last_buf_q;
        valid_d     = 1'b0;
        last_out_d  = last_out_q;
        state_out_d = state_out_q;
        unique case (state_q)
            SBSR_IDLE: begin
                if (tvalid) begin
                    in_buf_d   = state_in;
                    last_buf_d = last_in;
                    cnt_d      = '0;
                    state_d    = SBSR_BUSY;
                end
            end
            SBSR_BUSY: begin
                sub_buf_d = sub_full;
                if (cnt_q == CNT_W'(NPASS - 1)) begin
                    state_out_d = shift_rows(sub_full);
                    last_out_d  = last_buf_q;
                    valid_d     = 1'b1;
                    cnt_d       = '0;
                    state_d     = SBSR_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = SBSR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SBSR_IDLE;
            cnt_q       <= '0;
            in_buf_q    <= '0;
            sub_buf_q   <= '0;
            last_buf_q  <= 1'b0;
            valid_q     <= 1'b0;
            last_out_q  <= 1'b0;
            state_out_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_buf_q    <= in_buf_d;
            sub_buf_q   <= sub_buf_d;
            last_buf_q  <= last_buf_d;
            valid_q     <= valid_d;
            last_out_q  <= last_out_d;
            state_out_q <= state_out_d;
        end
    end

    always_comb begin
        ready     = (state_q == SBSR_IDLE);
        valid     = valid_q;
        last_out  = last_out_q;
        state_out = state_out_q;
    end

endmodule

// File: tb/tb_subbytes_shiftrows.sv
// Scoreboard bench for subbytes_shiftrows; reference S-box is derived from GF(2^8)
// inversion plus the affine map, independent of the RTL table.
module tb_subbytes_shiftrows;

    logic         clk;
    logic         reset;
    logic         tvalid;
    logic         last_in;
    logic [127:0] state_in;
    logic         ready;
    logic         valid;
    logic         last_out;
    logic [127:0] state_out;

    logic         sw_tvalid;
    logic [127:0] sw_state_in;
    logic         sw_ready     [5];
    logic         sw_valid     [5];
    logic         sw_last      [5];
    logic [127:0] sw_state_out [5];

    typedef struct {
        logic [127:0] st;
        logic         last;
        int           acc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_sbox [256];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    logic       prev_valid = 1'b0;

    localparam logic [127:0] KAT_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] KAT_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    subbytes_shiftrows #(.SBOX_LANES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .tvalid    (tvalid),
        .last_in   (last_in),
        .state_in  (state_in),
        .ready     (ready),
        .valid     (valid),
        .last_out  (last_out),
        .state_out (state_out)
    );

    for (genvar g = 0; g < 5; g++) begin : g_sweep
        subbytes_shiftrows #(.SBOX_LANES(1 << g)) u_sw (
            .clk       (clk),
            .reset     (reset),
            .tvalid    (sw_tvalid),
            .last_in   (1'b0),
            .state_in  (sw_state_in),
            .ready     (sw_ready[g]),
            .valid     (sw_valid[g]),
            .last_out  (sw_last[g]),
            .state_out (sw_state_out[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [7:0]   sb [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) sb[i] = ref_sbox[s[8*(15-i) +: 8]];
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(15-(4*c+r)) +: 8] = sb[4*((c+r)%4)+r];
        return o;
    endfunction

    task automatic send(input logic [127:0] s, input logic l, input logic [127:0] exp_s,
                        input logic hold, output int acc);
        int waited;
        exp_t e;
        waited   = 0;
        tvalid   = 1'b1;
        state_in = s;
        last_in  = l;
        while (!ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) begin
            check("send_timeout", ready, 1);
            tvalid = 1'b0;
            acc    = -1;
            return;
        end
        acc    = cyc + 1;
        e.st   = exp_s;
        e.last = l;
        e.acc  = acc;
        exp_q.push_back(e);
        @(negedge clk);
        if (!hold) tvalid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && valid) begin
            check("valid_gap", prev_valid, 0);
            check("ready_on_valid", ready, 1);
            if (exp_q.size() == 0) begin
                check("spurious_valid", valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("state_out", state_out, e.st);
                check("last_out", last_out, e.last);
                check("latency", cyc - e.acc, 4);
            end
        end
        prev_valid = valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1, acc2, seen;
        int lat   [5];
        logic [127:0] got_s [5];
        logic [127:0] a, b;
        logic hold;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            ref_sbox[x] = s;
        end

        reset       = 1'b1;
        tvalid      = 1'b0;
        last_in     = 1'b0;
        state_in    = '0;
        sw_tvalid   = 1'b0;
        sw_state_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_valid", valid, 0);
        check("rst_last", last_out, 0);
        check("rst_state", state_out, 128'h0);
        check("rst_ready", ready, 1);

        send(KAT_IN, 1'b0, KAT_OUT, 1'b0, acc1);
        drain();
        send(128'h0, 1'b1, {16{8'h63}}, 1'b0, acc1);
        drain();
        send({16{8'hff}}, 1'b1, {16{8'h16}}, 1'b0, acc1);
        drain();

        // Back-to-back: tvalid stays high, B presented while A is busy.
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        send(a, 1'b0, model(a), 1'b1, acc1);
        send(b, 1'b1, model(b), 1'b0, acc2);
        check("b2b_accept_gap", acc2 - acc1, 5);
        drain();

        send(KAT_IN, 1'b1, KAT_OUT, 1'b0, acc1);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        check("midrst_state", state_out, 128'h0);
        check("midrst_last", last_out, 0);
        check("midrst_ready", ready, 1);
        seen = 0;
        repeat (8) begin
            seen += int'(valid);
            @(negedge clk);
        end
        check("midrst_no_valid", seen, 0);

        for (int g = 0; g < 5; g++) begin
            lat[g]   = 0;
            got_s[g] = '0;
        end
        sw_tvalid   = 1'b1;
        sw_state_in = KAT_IN;
        acc1 = cyc + 1;
        @(negedge clk);
        sw_tvalid = 1'b0;
        repeat (20) begin
            for (int g = 0; g < 5; g++)
                if (sw_valid[g]) begin
                    lat[g]   = cyc - acc1;
                    got_s[g] = sw_state_out[g];
                end
            @(negedge clk);
        end
        for (int g = 0; g < 5; g++) begin
            check($sformatf("sweep%0d_latency", 1 << g), lat[g], 16 >> g);
            check($sformatf("sweep%0d_state", 1 << g), got_s[g], KAT_OUT);
        end

        for (int i = 0; i < 1000; i++) begin
            a    = {$urandom, $urandom, $urandom, $urandom};
            hold = 1'($urandom_range(0, 1));
            send(a, 1'($urandom_range(0, 1)), model(a), hold, acc1);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        tvalid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
